// File: rtl/cam_capture_fmt.sv
// Camera capture front-end: byte-pair pixel assembly, format conversion, crop and linear addressing.
// Write outputs are registered one pclk after the second byte; no backpressure, the sensor free-runs.
module cam_capture_fmt #(
  parameter int AW    = 15,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic          capture_en,
  input  logic [1:0]    fmt,
  output logic [AW-1:0] mem_px_addr,
  output logic [15:0]   mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          busy,
  output logic          line_err
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_LIM = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_LIM = RW'(IMG_H);
  localparam logic [AW-1:0] W_STEP  = AW'(IMG_W);

  typedef enum logic [1:0] {SYNC, ARM, CAPTURE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      fmt_q, fmt_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   base_q, base_d;
  logic            phase_q, phase_d;
  logic [7:0]      hi_q, hi_d;
  logic            line_act_q, line_act_d;
  logic            line_err_q, line_err_d;
  logic            px_wr_q, px_wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     data_q, data_d;
  logic            done_q, done_d;
  logic [15:0]     pix;

  function automatic logic [15:0] convert(input logic [1:0] f, input logic [15:0] p);
    case (f)
      2'd0:    convert = {8'h00, p[15:13], p[10:8], p[4:3]};
      2'd1:    convert = {4'h0, p[15:12], p[10:7], p[4:1]};
      default: convert = p;
    endcase
  endfunction

  assign pix = {hi_q, px_data};

  always_comb begin
    state_d    = state_q;
    fmt_d      = fmt_q;
    col_d      = col_q;
    row_d      = row_q;
    base_d     = base_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    line_act_d = line_act_q;
    line_err_d = line_err_q;
    px_wr_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    case (state_q)
      SYNC: if (vsync) state_d = SYNC == SYNC ? ARM : SYNC;
      ARM: begin
        if (!vsync) begin
          if (capture_en) begin
            state_d    = CAPTURE;
            fmt_d      = fmt;
            col_d      = '0;
            row_d      = '0;
            base_d     = '0;
            phase_d    = 1'b0;
            line_act_d = 1'b0;
            line_err_d = 1'b0;
          end else begin
            state_d = SYNC;
          end
        end
      end
      CAPTURE: begin
        if (vsync || !href) begin
          // A line closes on the first idle sample after it carried any byte, or at vsync.
          if (line_act_q) begin
            col_d      = '0;
            phase_d    = 1'b0;
            line_act_d = 1'b0;
            if (phase_q) line_err_d = 1'b1;
            if (row_q != ROW_LIM) begin
              row_d  = row_q + 1'b1;
              base_d = base_q + W_STEP;
            end
          end
          if (vsync) begin
            state_d = ARM;
            done_d  = 1'b1;
          end
        end else begin
          line_act_d = 1'b1;
          phase_d    = ~phase_q;
          if (!phase_q) begin
            hi_d = px_data;
          end else begin
            // Only in-window pixels write, so base+col never exceeds IMG_W*IMG_H-1.
            if (col_q < COL_LIM && row_q < ROW_LIM) begin
              px_wr_d = 1'b1;
              addr_d  = base_q + AW'(col_q);
              data_d  = convert(fmt_q, pix);
            end
            if (col_q != COL_LIM) col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= SYNC;
      fmt_q      <= 2'd0;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      phase_q    <= 1'b0;
      hi_q       <= 8'h00;
      line_act_q <= 1'b0;
      line_err_q <= 1'b0;
      px_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= 16'h0000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fmt_q      <= fmt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      line_act_q <= line_act_d;
      line_err_q <= line_err_d;
      px_wr_q    <= px_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = px_wr_q;
  assign frame_done  = done_q;
  assign busy        = (state_q == CAPTURE);
  assign line_err    = line_err_q;

endmodule

// File: doc/cam_capture_fmt.md
# cam_capture_fmt

Parametrised camera capture front-end for an OV7670-style sensor running in RGB565 two-byte-per-pixel mode. It synchronises to the sensor's vsync/href framing, assembles byte pairs into pixels and converts them to a runtime-selected storage format (RGB332, RGB444 or RGB565). It crops to a fixed window and generates linear frame-buffer write addresses. It sits between the camera pins and the frame-buffer RAM write port, entirely in the pixel-clock domain.

## Interface
- AW, 15, frame-buffer address width; IMG_W*IMG_H <= 2^AW is required.
- IMG_W, 160, pixels per stored line; incoming pixels at column >= IMG_W are dropped.
- IMG_H, 120, stored lines per frame; lines at row >= IMG_H are dropped.
- pclk  in  1  sensor pixel clock; the only clock. Everything is sampled and updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- vsync  in  1  frame sync; high = vertical blanking.
- href  in  1  line valid; one byte per pclk while high.
- px_data  in  8  sensor byte.
- capture_en  in  1  when high at a frame start, that frame is captured.
- fmt  in  2  output format: 0 = RGB332, 1 = RGB444, 2/3 = RGB565. Latched at frame start.
- mem_px_addr  out  AW  write address.
- mem_px_data  out  16  write data, zero-extended.
- px_wr  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- busy  out  1  high while in the CAPTURE state.
- line_err  out  1  sticky flag: a line ended on an odd byte count. Cleared at frame start.

## Operation
- FSM states: SYNC, ARM, CAPTURE.
- After reset the FSM is in SYNC.
  - SYNC -> ARM when vsync = 1, so capture never begins mid-frame.
  - ARM -> CAPTURE when vsync = 0 and capture_en = 1.
  - ARM -> SYNC when vsync = 0 and capture_en = 0; the frame is skipped.
- On the ARM->CAPTURE transition:
  - fmt is latched.
  - Column, row, address pointer and byte phase are cleared.
  - line_err is cleared.
- Pixel assembly in CAPTURE, with href = 1:
  - Phase 0 stores px_data as the high byte.
  - Phase 1 forms P = {high, px_data}, where R = P[15:11], G = P[10:5], B = P[4:0].
  - If column < IMG_W and row < IMG_H, the pixel is written.
  - The column increments on every pixel, whether written or not.
- Format conversion:
  - RGB332: data = {8'h00, R[4:2], G[5:3], B[4:3]}.
  - RGB444: data = {4'h0, R[4:1], G[5:2], B[4:1]}.
  - RGB565: data = P.
- End of line, detected on the href 1->0 edge:
  - Column and byte phase clear.
  - Row increments if the line contained at least one byte.
  - If the byte phase was 1, line_err is set and the dangling byte is discarded.
- Address pointer:
  - Starts at 0 and increments by 1 after each write, so a write's address equals row*IMG_W + column.
  - It saturates at IMG_W*IMG_H-1 and never wraps within a frame.
- href while vsync = 1, or outside CAPTURE, is ignored.
- CAPTURE -> ARM when vsync = 1. frame_done pulses in that transition cycle; a partial line is closed as described above.
- A 0 -> 1 change of capture_en mid-frame has no effect until the next frame start. A 1 -> 0 change does not abort the current frame.
- Reset values: mem_px_addr = 0, mem_px_data = 0, px_wr = 0, frame_done = 0, busy = 0, line_err = 0, FSM = SYNC.
- Asserting rst mid-frame drops the rest of that frame; capture resumes only after a full vsync high -> low sequence.

## Timing
- All inputs are sampled on the pclk rising edge. There is no internal input synchroniser, since the sensor is source-synchronous.
- Write latency: px_wr, mem_px_addr and mem_px_data are registered and valid in the cycle after the edge on which the second byte was sampled. All three change together.
- px_wr is high for exactly one cycle per stored pixel. The maximum rate is one write every 2 pclk.
- frame_done is registered, one cycle wide, and asserted in the cycle after vsync is first sampled high in CAPTURE.
- busy is asserted one cycle after vsync is sampled low in ARM with capture_en = 1, and deasserts together with frame_done.
- line_err is set one cycle after href is sampled low following an odd byte count.

## Test plan
- IMG_W=4, IMG_H=2, fmt=2. Frame of 2 lines x 8 bytes (bytes 0x00..0x0F) -> 8 writes:
  - addr 0..7 with data 0x0001, 0x0203, …, 0x0E0F.
  - One frame_done pulse at vsync rise.
  - line_err = 0.
- Same frame, fmt=0, pixel 0xF81F -> data 0x00E3. fmt=1, pixel 0x07E0 -> data 0x00F0.
- Crop test: IMG_W=4, IMG_H=2. Sensor sends 3 lines of 6 pixels -> exactly 8 writes (addr 0..7); pixels 5–6 of each line and all of line 3 produce no px_wr.
- Sync tests:
  - Reset released with vsync low mid-frame -> no writes until a vsync high then low is seen.
  - capture_en = 0 at the frame start -> whole frame skipped, no frame_done.
- Odd line: a 7-byte line -> 3 writes, line_err = 1. The next line starts at phase 0 at address row*IMG_W. line_err clears at the next frame start.
- rst asserted after the 3rd write -> all outputs 0 asynchronously. The next full frame is captured starting from addr 0.
